game_ctrl: RTL and testbench

- Top-level game sequencer for the Dino datapath.
- Owns the play/death/restart state machine and drives the score counter's `game_start` / `game_over` / `game_tick` pulses, plus a one-cycle score clear.
- Latches the high score and derives a saturating speed level from score progress for the obstacle generator.
- Sits between the input/frame-timing logic and the score/obstacle/render blocks.

---
 rtl/dino_pkg.sv | 15 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/game_ctrl.sv | 153 +++++++++++++++
 tb/tb_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and widths for the Dino game datapath.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DYING   = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    localparam int SCORE_W     = 16;
    localparam int DIGIT_W     = 4;
    localparam int SPEED_W_DEF = 3;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + stability debounce + one-cycle rising-edge pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES to level_o, press_o same cycle; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Dino game sequencer: play/death/restart FSM, score pulses, high score, speed level.
// All outputs registered, one cycle after the causing input; no backpressure.
module game_ctrl
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEATH_FRAMES    = 30,
    parameter int MAX_SPEED       = 7,
    parameter int SPEED_W         = SPEED_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_jump,
    input  logic               collision,
    input  logic               frame_end,
    input  logic [SCORE_W-1:0] score,
    output logic               game_start,
    output logic               game_over,
    output logic               game_tick,
    output logic               score_rst_n,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] hi_score,
    output logic               new_record,
    output logic [SPEED_W-1:0] speed
);

    localparam int DCNT_W = $clog2(DEATH_FRAMES + 1);

    logic press;
    logic btn_level;

    state_e             state_q, state_d;
    logic               start_q, start_d;
    logic               over_q, over_d;
    logic               tick_q, tick_d;
    logic               srst_n_q, srst_n_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic               rec_q, rec_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [DIGIT_W-1:0] hund_q, hund_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_jump),
        .level_o(btn_level),
        .press_o(press)
    );

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        over_d   = 1'b0;
        tick_d   = 1'b0;
        srst_n_d = 1'b1;
        hi_d     = hi_q;
        rec_d    = rec_q;
        speed_d  = speed_q;
        hund_d   = hund_q;
        dcnt_d   = dcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_RUNNING;
                    start_d = 1'b1;
                    speed_d = '0;
                    hund_d  = score[11:8];
                end
            end
            ST_RUNNING: begin
                // Any hundreds-digit change (including 9999 -> 0000 wrap) is one speed step.
                if (hund_q != score[11:8]) begin
                    hund_d = score[11:8];
                    if (speed_q != SPEED_W'(MAX_SPEED)) begin
                        speed_d = speed_q + SPEED_W'(1);
                    end
                end
                if (collision) begin
                    state_d = ST_DYING;
                    over_d  = 1'b1;
                    dcnt_d  = '0;
                end else begin
                    tick_d = frame_end;
                end
            end
            ST_DYING: begin
                if (frame_end) begin
                    if (dcnt_q == DCNT_W'(DEATH_FRAMES - 1)) begin
                        state_d = ST_OVER;
                        if (score > hi_q) begin
                            hi_d  = score;
                            rec_d = 1'b1;
                        end else begin
                            rec_d = 1'b0;
                        end
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (press) begin
                    state_d  = ST_IDLE;
                    srst_n_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            over_q   <= 1'b0;
            tick_q   <= 1'b0;
            srst_n_q <= 1'b1;
            hi_q     <= '0;
            rec_q    <= 1'b0;
            speed_q  <= '0;
            hund_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            over_q   <= over_d;
            tick_q   <= tick_d;
            srst_n_q <= srst_n_d;
            hi_q     <= hi_d;
            rec_q    <= rec_d;
            speed_q  <= speed_d;
            hund_q   <= hund_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign game_start  = start_q;
    assign game_over   = over_q;
    assign game_tick   = tick_q;
    assign score_rst_n = srst_n_q;
    assign state       = state_q;
    assign hi_score    = hi_q;
    assign new_record  = rec_q;
    assign speed       = speed_q;

    // The debounced level itself is not needed here; only its rising edge.
    logic unused_level;
    assign unused_level = btn_level;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: table-driven RUNNING vectors plus hand sequences.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_jump = 1'b0;
    logic        collision = 1'b0;
    logic        frame_end = 1'b0;
    logic [15:0] score = 16'h0000;

    logic        game_start, game_over, game_tick, score_rst_n, new_record;
    logic [1:0]  state;
    logic [15:0] hi_score;
    logic [2:0]  speed;

    int total = 0;
    int bad = 0;

    game_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .DEATH_FRAMES   (30),
        .MAX_SPEED      (7),
        .SPEED_W        (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_jump   (btn_jump),
        .collision  (collision),
        .frame_end  (frame_end),
        .score      (score),
        .game_start (game_start),
        .game_over  (game_over),
        .game_tick  (game_tick),
        .score_rst_n(score_rst_n),
        .state      (state),
        .hi_score   (hi_score),
        .new_record (new_record),
        .speed      (speed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       coll;
        logic       fe;
        logic [1:0] st;
        logic       tk;
        logic       ov;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press for 22 cycles then release for 22; counts start pulses and score clears.
    task automatic press_rel(output int n_start, output int n_srst);
        n_start = 0;
        n_srst  = 0;
        btn_jump = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (i == 22) btn_jump = 1'b0;
            tick();
            if (game_start) n_start++;
            if (!score_rst_n) n_srst++;
        end
    endtask

    task automatic frames(input string nm, input int n);
        int n_tick;
        n_tick = 0;
        for (int i = 0; i < n; i++) begin
            frame_end = 1'b1;
            tick();
            if (game_tick) n_tick++;
            frame_end = 1'b0;
            if (i == n - 2) chk({nm, "_still_dying"}, 32'(state), 32'd2);
            tick();
            if (game_tick) n_tick++;
        end
        chk({nm, "_no_tick_dying"}, 32'(n_tick), 32'd0);
    endtask

    task automatic collide(input string nm);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk({nm, "_game_over"}, 32'(game_over), 32'd1);
        chk({nm, "_state_dying"}, 32'(state), 32'd2);
    endtask

    initial begin
        int n_start, n_srst, n_pulse, first;

        tbl[0]  = '{coll:1'b0, fe:1'b1, st:2'd1, tk:1'b1, ov:1'b0};
        tbl[1]  = '{coll:1'b0, fe:1'b0, st:2'd1, tk:1'b0, ov:1'b0};
        tbl[2]  = '{coll:1'b0, fe:1'b1, st:2'd1, tk:1'b1, ov:1'b0};
        tbl[3]  = '{coll:1'b0, fe:1'b0, st:2'd1, tk:1'b0, ov:1'b0};
        tbl[4]  = '{coll:1'b0, fe:1'b1, st:2'd1, tk:1'b1, ov:1'b0};
        tbl[5]  = '{coll:1'b0, fe:1'b0, st:2'd1, tk:1'b0, ov:1'b0};
        tbl[6]  = '{coll:1'b0, fe:1'b1, st:2'd1, tk:1'b1, ov:1'b0};
        tbl[7]  = '{coll:1'b0, fe:1'b0, st:2'd1, tk:1'b0, ov:1'b0};
        tbl[8]  = '{coll:1'b0, fe:1'b1, st:2'd1, tk:1'b1, ov:1'b0};
        tbl[9]  = '{coll:1'b0, fe:1'b0, st:2'd1, tk:1'b0, ov:1'b0};
        tbl[10] = '{coll:1'b1, fe:1'b1, st:2'd2, tk:1'b0, ov:1'b1};
        tbl[11] = '{coll:1'b0, fe:1'b0, st:2'd2, tk:1'b0, ov:1'b0};

        // Reset hold and release
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_srst_n", 32'(score_rst_n), 32'd1);
        rst_n = 1'b1;
        n_pulse = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (game_start || game_over || game_tick || !score_rst_n) n_pulse++;
        end
        chk("idle_no_pulses", 32'(n_pulse), 32'd0);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_hi", 32'(hi_score), 32'h0);
        chk("idle_speed", 32'(speed), 32'd0);
        chk("idle_rec", 32'(new_record), 32'd0);

        // 10-cycle glitch gives no start
        btn_jump = 1'b1;
        repeat (10) tick();
        btn_jump = 1'b0;
        n_start = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (game_start) n_start++;
        end
        chk("glitch_no_start", 32'(n_start), 32'd0);
        chk("glitch_state", 32'(state), 32'd0);

        // Run 1: press latency, then frame/tick table, collision at score 0x0050
        score = 16'h0050;
        btn_jump = 1'b1;
        n_start = 0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (game_start) begin
                n_start++;
                if (first == 0) first = k;
            end
        end
        btn_jump = 1'b0;
        chk("start_latency", 32'(first), 32'd19);
        chk("start_count", 32'(n_start), 32'd1);
        chk("run_state", 32'(state), 32'd1);
        chk("run_speed0", 32'(speed), 32'd0);
        repeat (25) tick();
        for (int i = 0; i < 12; i++) begin
            collision = tbl[i].coll;
            frame_end = tbl[i].fe;
            tick();
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_tick", i), 32'(game_tick), 32'(tbl[i].tk));
            chk($sformatf("tbl%0d_over", i), 32'(game_over), 32'(tbl[i].ov));
        end
        collision = 1'b0;
        frame_end = 1'b0;
        frames("run1", 30);
        chk("run1_over_state", 32'(state), 32'd3);
        chk("run1_hi", 32'(hi_score), 32'h0050);
        chk("run1_rec", 32'(new_record), 32'd1);
        press_rel(n_start, n_srst);
        chk("run1_restart_state", 32'(state), 32'd0);
        chk("run1_srst_once", 32'(n_srst), 32'd1);
        chk("run1_restart_nostart", 32'(n_start), 32'd0);

        // Run 2: ends at 0x0123 with button held through DYING and OVER
        score = 16'h0000;
        press_rel(n_start, n_srst);
        chk("run2_start", 32'(n_start), 32'd1);
        chk("run2_state", 32'(state), 32'd1);
        score = 16'h0123;
        tick();
        collide("run2");
        btn_jump = 1'b1;
        frames("run2", 30);
        chk("run2_over_state", 32'(state), 32'd3);
        chk("run2_hi", 32'(hi_score), 32'h0123);
        chk("run2_rec", 32'(new_record), 32'd1);
        repeat (30) tick();
        chk("run2_held_stays_over", 32'(state), 32'd3);
        btn_jump = 1'b0;
        repeat (25) tick();
        chk("run2_release_stays_over", 32'(state), 32'd3);
        press_rel(n_start, n_srst);
        chk("run2_restart_state", 32'(state), 32'd0);
        chk("run2_srst_once", 32'(n_srst), 32'd1);

        // Run 3: equal score keeps hi_score and clears new_record
        score = 16'h0000;
        press_rel(n_start, n_srst);
        chk("run3_state", 32'(state), 32'd1);
        chk("run3_rec_kept", 32'(new_record), 32'd1);
        score = 16'h0123;
        tick();
        collide("run3");
        frames("run3", 30);
        chk("run3_over_state", 32'(state), 32'd3);
        chk("run3_hi", 32'(hi_score), 32'h0123);
        chk("run3_rec", 32'(new_record), 32'd0);
        press_rel(n_start, n_srst);
        chk("run3_restart_state", 32'(state), 32'd0);

        // Run 4: speed ramp and saturation
        score = 16'h0099;
        press_rel(n_start, n_srst);
        chk("run4_state", 32'(state), 32'd1);
        chk("run4_speed0", 32'(speed), 32'd0);
        for (int h = 1; h <= 9; h++) begin
            score = 16'(h) << 8;
            tick();
            tick();
            chk($sformatf("speed_h%0d", h), 32'(speed), 32'((h > 7) ? 7 : h));
        end
        collide("run4");
        frames("run4", 30);
        chk("run4_hi", 32'(hi_score), 32'h0900);
        chk("run4_rec", 32'(new_record), 32'd1);
        press_rel(n_start, n_srst);
        chk("run4_restart_state", 32'(state), 32'd0);
        score = 16'h0000;
        press_rel(n_start, n_srst);
        chk("run5_state", 32'(state), 32'd1);
        chk("run5_speed_reset", 32'(speed), 32'd0);

        // Reset mid-run with a coincident collision
        collision = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_hi", 32'(hi_score), 32'h0);
        chk("midrst_rec", 32'(new_record), 32'd0);
        n_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (game_over || game_start || game_tick) n_pulse++;
        end
        chk("midrst_no_pulse", 32'(n_pulse), 32'd0);
        collision = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("midrst_after_state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
